memory_interface: RTL and testbench

MEMORY_INTERFACE -- requirements
Module: memory_interface

---
 rtl/mem_if_pkg.sv | 21 ++
 rtl/memory_interface_if.sv | 37 +++
 rtl/memory_interface.sv | 108 ++++++++++
 tb/tb_memory_interface.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory access sequencer, the RAM and the MAR/MDR blocks.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned WAIT_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    DONE
  } mem_state_e;

  // Values above 7 do not fit the 3-bit wait counter, so they saturate at 7.
  function automatic logic [WAIT_W-1:0] wait_load(input int unsigned n);
    return (n > 7) ? '1 : WAIT_W'(n);
  endfunction

endpackage

// File: rtl/memory_interface_if.sv
// CPU-side request/response and RAM-side strobe bundle for memory_interface.
interface memory_interface_if
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);

  // CPU side
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;

  // RAM side
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // The sequencer itself
  modport slave (
    input  mem_req, mem_wr, addr_in, wdata, ram_rdata,
    output rdata, busy, done, ram_read, ram_write, ram_address, ram_wdata
  );

  // The surrounding CPU datapath and RAM
  modport master (
    output mem_req, mem_wr, addr_in, wdata, ram_rdata,
    input  rdata, busy, done, ram_read, ram_write, ram_address, ram_wdata
  );

endinterface

// File: rtl/memory_interface.sv
// memory_interface: sequences one CPU read or write into a synchronous RAM.
// All outputs are registered; nothing is combinationally derived from mem_req.
module memory_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              clr,
  memory_interface_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  mem_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              read_q;
  logic              write_q;
  logic              busy_q;
  logic              done_q;

  // Access FSM; strobes, busy and done are set on the edge that enters the
  // state they belong to, so each output equals a decode of the current state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q   <= bus.addr_in;
            wdata_q  <= bus.wdata;
            wait_cnt <= WAIT_LOAD;
            busy_q   <= 1'b1;
            if (bus.mem_wr) begin
              state   <= WR_ISSUE;
              write_q <= 1'b1;
            end else begin
              state  <= RD_ISSUE;
              read_q <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          if (wait_cnt == '0) begin
            state  <= RD_CAPTURE;
            read_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RD_CAPTURE: begin
          rdata_q <= bus.ram_rdata;
          done_q  <= 1'b1;
          state   <= DONE;
        end
        WR_ISSUE: begin
          if (wait_cnt == '0) begin
            state   <= DONE;
            write_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ram_read    = read_q;
  assign bus.ram_write   = write_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wdata_q;

  // Strobes are mutually exclusive and done never lasts beyond one cycle.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!clr) !(read_q && write_q));
  a_done_pulse:  assert property (@(posedge clk) disable iff (!clr) done_q |=> !done_q);
  a_busy_state:  assert property (@(posedge clk) disable iff (!clr) busy_q == (state != IDLE));

endmodule

// File: tb/tb_memory_interface.sv
// Bench: two sequencers (WAIT_CYCLES 0 and 2), each paired with a 512x32
// synchronous RAM; a driver pushes expected responses into a scoreboard and
// a per-instance monitor checks strobes, latency and rdata.
`timescale 1ns/1ps
module tb_memory_interface;
  import mem_if_pkg::*;

  localparam int unsigned AW    = MEM_ADDR_W;
  localparam int unsigned DW    = MEM_DATA_W;
  localparam int unsigned DEPTH = 1 << AW;
  // Driven by the RAM when its read strobe is low (stands in for X).
  localparam logic [DW-1:0] POISON = 32'hBADC_0FFE;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rdata;
    int unsigned   acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] clr   = '0;
  logic [1:0] req   = '0;
  logic [1:0] wr_i  = '0;
  logic [1:0] pl_en = '0;
  logic [AW-1:0] addr_i  [2];
  logic [DW-1:0] wd_i    [2];
  logic [AW-1:0] pl_addr [2];
  logic [DW-1:0] pl_data [2];

  logic [1:0] busy_w, done_w, rd_w, wrs_w;
  logic [AW-1:0] raddr_w [2];
  logic [DW-1:0] rwd_w   [2];
  logic [DW-1:0] rdata_w [2];

  // Reference model: scoreboard, memory contents and the values the
  // sequencer must hold between accesses.
  exp_t          sb        [2][$];
  logic [DW-1:0] model_mem [2][DEPTH];
  logic [DW-1:0] last_rd   [2];
  logic [DW-1:0] last_wd   [2];
  logic [AW-1:0] last_addr [2];
  logic [AW-1:0] known     [2][$];
  int unsigned   strobes   [2];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned WC = (g == 0) ? 0 : 2;

    memory_interface_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;

    memory_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
      .clk (clk),
      .clr (clr[g]),
      .bus (bus)
    );

    assign bus.mem_req   = req[g];
    assign bus.mem_wr    = wr_i[g];
    assign bus.addr_in   = addr_i[g];
    assign bus.wdata     = wd_i[g];
    assign bus.ram_rdata = ram_q;

    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign rd_w[g]    = bus.ram_read;
    assign wrs_w[g]   = bus.ram_write;
    assign raddr_w[g] = bus.ram_address;
    assign rwd_w[g]   = bus.ram_wdata;
    assign rdata_w[g] = bus.rdata;

    // 512x32 synchronous RAM with registered output and a preload port.
    always @(posedge clk) begin
      if (pl_en[g]) ram[pl_addr[g]] <= pl_data[g];
      else if (bus.ram_write) ram[bus.ram_address] <= bus.ram_wdata;
      if (bus.ram_read) ram_q <= ram[bus.ram_address];
      else ram_q <= POISON;
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : mon
      exp_t        head;
      int unsigned lat_exp;
      forever begin
        @(negedge clk);
        if (clr[g]) begin
          check("strobe_exclusive", {63'd0, bus.ram_read & bus.ram_write}, 64'd0);
          check("busy_vs_outstanding", {63'd0, bus.busy}, {63'd0, sb[g].size() != 0});
          if (bus.ram_read || bus.ram_write) begin
            if (sb[g].size() == 0) begin
              check("stray_strobe", {62'd0, bus.ram_read, bus.ram_write}, 64'd0);
            end else begin
              head = sb[g][0];
              check("strobe_kind", {62'd0, bus.ram_read, bus.ram_write}, head.wr ? 64'd1 : 64'd2);
              check("strobe_addr", {55'd0, bus.ram_address}, {55'd0, head.addr});
              if (head.wr) check("strobe_wdata", {32'd0, bus.ram_wdata}, {32'd0, head.data});
              strobes[g]++;
            end
          end
          if (bus.done) begin
            if (sb[g].size() == 0) begin
              check("stray_done", {63'd0, bus.done}, 64'd0);
            end else begin
              head = sb[g].pop_front();
              // Done is high in cycle (WAIT+1 issue cycles) + capture (reads) + 1,
              // counting the first cycle after the accepting edge as cycle 1.
              lat_exp = head.wr ? WC + 2 : WC + 3;
              check("done_latency", 64'(cyc - head.acc + 1), 64'(lat_exp));
              check("strobe_cycles", 64'(strobes[g]), 64'(WC + 1));
              if (head.wr) check("rdata_after_write", {32'd0, bus.rdata}, {32'd0, head.exp_rdata});
              else         check("rdata_read", {32'd0, bus.rdata}, {32'd0, head.exp_rdata});
              strobes[g] = 0;
            end
          end else if (!bus.busy) begin
            check("idle_ram_address", {55'd0, bus.ram_address}, {55'd0, last_addr[g]});
            check("idle_ram_wdata", {32'd0, bus.ram_wdata}, {32'd0, last_wd[g]});
          end
        end
      end
    end
  end

  task automatic preload(input int unsigned g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en[g] = 1'b1; pl_addr[g] = a; pl_data[g] = d;
    @(negedge clk);
    pl_en[g] = 1'b0;
    model_mem[g][a] = d;
    known[g].push_back(a);
  endtask

  // Presents a request and returns once it is accepted (busy rises).
  task automatic access(input int unsigned g, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hold,
                        output int unsigned edges, output int unsigned acc);
    bit   prev, got;
    exp_t e;
    @(negedge clk);
    req[g] = 1'b1; wr_i[g] = wr; addr_i[g] = a; wd_i[g] = d;
    prev = busy_w[g]; got = 1'b0; edges = 0; acc = 0;
    while (!got && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (busy_w[g] && !prev) got = 1'b1;
      prev = busy_w[g];
    end
    if (!got) begin
      check("accept_timeout", {63'd0, got}, 64'd1);
      req[g] = 1'b0;
    end else begin
      acc    = cyc;
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      e.acc  = acc;
      if (wr) begin
        e.exp_rdata     = last_rd[g];
        model_mem[g][a] = d;
      end else begin
        e.exp_rdata = model_mem[g][a];
        last_rd[g]  = e.exp_rdata;
      end
      last_addr[g] = a;
      last_wd[g]   = d;
      sb[g].push_back(e);
      if (!hold) req[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int unsigned g);
    int unsigned n = 0;
    while ((sb[g].size() != 0 || busy_w[g]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 64'(sb[g].size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input int unsigned g);
    check("reset_ctrl", {60'd0, busy_w[g], done_w[g], rd_w[g], wrs_w[g]}, 64'd0);
    check("reset_ram_address", {55'd0, raddr_w[g]}, 64'd0);
    check("reset_ram_wdata", {32'd0, rwd_w[g]}, 64'd0);
    check("reset_rdata", {32'd0, rdata_w[g]}, 64'd0);
  endtask

  task automatic clear_model(input int unsigned g);
    sb[g].delete();
    strobes[g]   = 0;
    last_rd[g]   = '0;
    last_wd[g]   = '0;
    last_addr[g] = '0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int unsigned   edges, acc0, acc1, acc2;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    for (int unsigned g = 0; g < 2; g++) begin
      addr_i[g] = '0; wd_i[g] = '0; pl_addr[g] = '0; pl_data[g] = '0;
      clear_model(g);
    end

    #3;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    clr = 2'b11;

    // Write then read back 0x05.
    access(0, 1'b1, 9'h005, 32'h1234_5678, 1'b0, edges, acc0);
    check("accept_from_idle", 64'(edges), 64'd1);
    wait_idle(0);
    access(0, 1'b0, 9'h005, 32'h0, 1'b0, edges, acc0);
    wait_idle(0);

    // Top-of-range read, then a write to 0x000 must not disturb rdata.
    preload(0, 9'h1FF, 32'hDEAD_BEEF);
    access(0, 1'b0, 9'h1FF, 32'h0, 1'b0, edges, acc0);
    wait_idle(0);
    access(0, 1'b1, 9'h000, 32'hAAAA_AAAA, 1'b0, edges, acc0);
    wait_idle(0);
    check("rdata_kept_over_write", {32'd0, rdata_w[0]}, 64'hDEAD_BEEF);

    // A second request while busy must be ignored.
    preload(0, 9'h020, 32'h0BAD_F00D);
    preload(0, 9'h010, 32'h1111_0010);
    access(0, 1'b0, 9'h020, 32'h0, 1'b1, edges, acc0);
    addr_i[0] = 9'h010; wr_i[0] = 1'b1; wd_i[0] = 32'hFFFF_0000;
    @(posedge clk); @(posedge clk); #1;
    req[0] = 1'b0;
    wait_idle(0);
    access(0, 1'b0, 9'h010, 32'h0, 1'b0, edges, acc0);
    wait_idle(0);

    // Back-to-back reads with mem_req held high.
    preload(0, 9'h001, 32'h11);
    preload(0, 9'h002, 32'h22);
    preload(0, 9'h003, 32'h33);
    access(0, 1'b0, 9'h001, 32'h0, 1'b1, edges, acc0);
    access(0, 1'b0, 9'h002, 32'h0, 1'b1, edges, acc1);
    access(0, 1'b0, 9'h003, 32'h0, 1'b0, edges, acc2);
    // 3-cycle read plus one IDLE cycle between accepting edges.
    check("b2b_gap_1", 64'(acc1 - acc0), 64'd4);
    check("b2b_gap_2", 64'(acc2 - acc1), 64'd4);
    wait_idle(0);

    // Instance with WAIT_CYCLES=2.
    preload(1, 9'h0AB, 32'h5A5A_C3C3);
    access(1, 1'b0, 9'h0AB, 32'h0, 1'b0, edges, acc0);
    wait_idle(1);
    access(1, 1'b1, 9'h1FF, 32'h0F0F_1234, 1'b0, edges, acc0);
    wait_idle(1);
    known[1].push_back(9'h1FF);

    // Randomized traffic; reads only from addresses with known contents.
    for (int unsigned g = 0; g < 2; g++) begin
      for (int unsigned i = 0; i < 40; i++) begin
        w = 1'(($urandom_range(0, 1)));
        if (w || known[g].size() == 0) a = AW'($urandom_range(0, DEPTH - 1));
        else a = known[g][$urandom_range(0, known[g].size() - 1)];
        d = $urandom;
        access(g, w, a, d, (i != 39) && ($urandom_range(0, 1) == 1), edges, acc0);
        if (w) known[g].push_back(a);
      end
      wait_idle(g);
    end

    // Reset in the middle of a write: strobe and busy drop at once, no done.
    preload(0, 9'h007, 32'h0700_0007);
    access(0, 1'b1, 9'h030, 32'hCAFE_F00D, 1'b0, edges, acc0);
    #1;
    check("wr_issue_strobe", {63'd0, wrs_w[0]}, 64'd1);
    clr[0] = 1'b0;
    #1;
    check("reset_drops_write", {61'd0, wrs_w[0], busy_w[0], done_w[0]}, 64'd0);
    check_reset_state(0);
    clear_model(0);
    @(negedge clk); @(negedge clk);
    #2;
    clr[0] = 1'b1;
    access(0, 1'b0, 9'h007, 32'h0, 1'b0, edges, acc0);
    check("first_req_after_clr", 64'(edges), 64'd1);
    wait_idle(0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
